gain_oot_regs: RTL

Control-port responder for the gain_oot block. Sits on the client side of the block's NoC shell, terminating the CtrlPort master that the shell drives toward user logic. Provides the block's register map: the gain coefficient consumed by the datapath, a compatibility ID, a scratch register, and packet counters for the input and output payload streams.

---
 rtl/gain_oot_regs_pkg.sv | 22 ++
 rtl/gain_oot_regs_pkt_event_counter.sv | 42 ++++
 rtl/gain_oot_regs.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gain_oot_regs_pkg.sv
// gain_oot_regs_pkg
// Shared constants for the gain_oot control-port register block:
//   - register byte offsets inside the 32-byte window
//   - CTRL register bit positions
//   - gain coefficient width and the window address width
package gain_oot_regs_pkg;

    localparam int GAIN_W = 16;
    // Low address bits that select a register inside the block's window.
    localparam int WIN_W  = 5;

    localparam logic [WIN_W-1:0] REG_COMPAT      = 5'h00;
    localparam logic [WIN_W-1:0] REG_GAIN        = 5'h04;
    localparam logic [WIN_W-1:0] REG_SCRATCH     = 5'h08;
    localparam logic [WIN_W-1:0] REG_IN_PKT_CNT  = 5'h0C;
    localparam logic [WIN_W-1:0] REG_OUT_PKT_CNT = 5'h10;
    localparam logic [WIN_W-1:0] REG_CTRL        = 5'h14;

    localparam int CTRL_CLR_CNT  = 0;   // clear both packet counters
    localparam int CTRL_RST_GAIN = 1;   // restore GAIN to its reset value

endpackage

// File: rtl/gain_oot_regs_pkt_event_counter.sv
// pkt_event_counter
// Counts completed packets on an AXI-Stream style tap: one count per cycle
// with tvalid & tready & tlast. Wraps at 2^32. A clear in the same cycle as
// an event wins.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   tvalid, tready, tlast - monitored handshake signals
//   clr                   - synchronous clear
//   count                 - current packet count
module pkt_event_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tvalid,
    input  logic        tready,
    input  logic        tlast,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tvalid && tready && tlast) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gain_oot_regs.sv
// gain_oot_regs
// CtrlPort responder holding the gain_oot register map: COMPAT, GAIN,
// SCRATCH, input/output packet counters and a write-only CTRL register.
// Every request that decodes into the 32-byte window is acked exactly one
// cycle later; requests outside the window are ignored entirely so another
// responder can share the bus.
// Ports:
//   ctrlport_clk, ctrlport_rst_n - clock, asynchronous active-low reset
//   s_ctrlport_req_*             - request strobes, byte address, write data
//   s_ctrlport_resp_ack/data     - registered response (data 0 when no ack)
//   in_t*/out_t*                 - stream taps for packet counting
//   gain, gain_update            - gain coefficient and its change pulse
module gain_oot_regs
    import gain_oot_regs_pkg::*;
#(
    parameter logic [19:0]       BASE_ADDR  = 20'h00000,
    parameter logic [31:0]       COMPAT_NUM = 32'h0001_0000,
    parameter logic [GAIN_W-1:0] GAIN_RESET = 16'd1
) (
    input  logic              ctrlport_clk,
    input  logic              ctrlport_rst_n,
    input  logic              s_ctrlport_req_wr,
    input  logic              s_ctrlport_req_rd,
    input  logic [19:0]       s_ctrlport_req_addr,
    input  logic [31:0]       s_ctrlport_req_data,
    output logic              s_ctrlport_resp_ack,
    output logic [31:0]       s_ctrlport_resp_data,
    input  logic              in_tvalid,
    input  logic              in_tready,
    input  logic              in_tlast,
    input  logic              out_tvalid,
    input  logic              out_tready,
    input  logic              out_tlast,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_update
);

    logic              resp_ack_q,  resp_ack_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [GAIN_W-1:0] gain_q,      gain_d;
    logic              gain_upd_q,  gain_upd_d;
    logic [31:0]       scratch_q,   scratch_d;

    logic              hit;
    logic              wr_en;
    logic              cnt_clr;
    logic [WIN_W-1:0]  offset;
    logic [31:0]       rd_val;
    logic [31:0]       in_cnt;
    logic [31:0]       out_cnt;
    logic [1:0]        unused_addr_lsb;

    assign unused_addr_lsb = s_ctrlport_req_addr[1:0];

    // Byte lanes are not used: the offset is word aligned.
    assign offset = {s_ctrlport_req_addr[WIN_W-1:2], 2'b00};
    assign hit    = (s_ctrlport_req_wr || s_ctrlport_req_rd) &&
                    (s_ctrlport_req_addr[19:WIN_W] == BASE_ADDR[19:WIN_W]);
    // A simultaneous wr+rd is a write; the read path still reports the
    // register contents as they were before this edge.
    assign wr_en  = hit && s_ctrlport_req_wr;

    always_comb begin
        rd_val = '0;
        case (offset)
            REG_COMPAT:      rd_val = COMPAT_NUM;
            REG_GAIN:        rd_val = {{(32-GAIN_W){1'b0}}, gain_q};
            REG_SCRATCH:     rd_val = scratch_q;
            REG_IN_PKT_CNT:  rd_val = in_cnt;
            REG_OUT_PKT_CNT: rd_val = out_cnt;
            default:         rd_val = '0;
        endcase
    end

    always_comb begin
        resp_ack_d  = hit;
        resp_data_d = hit ? rd_val : '0;
        gain_d      = gain_q;
        gain_upd_d  = 1'b0;
        scratch_d   = scratch_q;
        cnt_clr     = 1'b0;
        if (wr_en) begin
            case (offset)
                REG_GAIN: begin
                    gain_d     = s_ctrlport_req_data[GAIN_W-1:0];
                    gain_upd_d = 1'b1;
                end
                REG_SCRATCH: begin
                    scratch_d = s_ctrlport_req_data;
                end
                REG_CTRL: begin
                    cnt_clr = s_ctrlport_req_data[CTRL_CLR_CNT];
                    if (s_ctrlport_req_data[CTRL_RST_GAIN]) begin
                        gain_d     = GAIN_RESET;
                        gain_upd_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            resp_ack_q  <= 1'b0;
            resp_data_q <= '0;
            gain_q      <= GAIN_RESET;
            gain_upd_q  <= 1'b0;
            scratch_q   <= '0;
        end else begin
            resp_ack_q  <= resp_ack_d;
            resp_data_q <= resp_data_d;
            gain_q      <= gain_d;
            gain_upd_q  <= gain_upd_d;
            scratch_q   <= scratch_d;
        end
    end

    // The clear is combinational from the request so it lands on the same
    // edge as the write's ack, overriding any increment in that cycle.
    pkt_event_counter u_in_cnt (
        .clk    (ctrlport_clk),
        .rst_n  (ctrlport_rst_n),
        .tvalid (in_tvalid),
        .tready (in_tready),
        .tlast  (in_tlast),
        .clr    (cnt_clr),
        .count  (in_cnt)
    );

    pkt_event_counter u_out_cnt (
        .clk    (ctrlport_clk),
        .rst_n  (ctrlport_rst_n),
        .tvalid (out_tvalid),
        .tready (out_tready),
        .tlast  (out_tlast),
        .clr    (cnt_clr),
        .count  (out_cnt)
    );

    assign s_ctrlport_resp_ack  = resp_ack_q;
    assign s_ctrlport_resp_data = resp_data_q;
    assign gain                 = gain_q;
    assign gain_update          = gain_upd_q;

endmodule
